// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one N-bit NOT/AND/OR/XOR unit between two requesters, result in a valid/ready output register
module logic_unit_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_id,
    output logic [N-1:0] resp_data
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t         state;
    logic           last;
    logic           can_accept;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic [1:0]     op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   result;
    always_comb begin
        can_accept = state == EMPTY || resp_ready;
        grant0     = req0_valid && (!req1_valid || last);
        grant1     = req1_valid && (!req0_valid || !last);
        req0_ready = grant0 && can_accept && !rst;
        req1_ready = grant1 && can_accept && !rst;
        accept     = req0_ready || req1_ready;
        op         = grant1 ? req1_op : req0_op;
        a          = grant1 ? req1_a : req0_a;
        b          = grant1 ? req1_b : req0_b;
    end
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign result[i] = op == 2'b00 ? ~a[i] :
                           op == 2'b01 ? a[i] & b[i] :
                           op == 2'b10 ? a[i] | b[i] : a[i] ^ b[i];
    end
    assign resp_valid = state == FULL;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            resp_id   <= 1'b0;
            resp_data <= '0;
            last      <= 1'b1;
        end else if (accept) begin
            state     <= FULL;
            resp_id   <= req1_ready;
            resp_data <= result;
            last      <= req1_ready;
        end else if (resp_ready) begin
            state     <= EMPTY;
        end
    end
endmodule
